// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   FWD_*       : encodings of the E-stage operand forwarding mux select
//   md_state_t  : mult/div sequencer state encoding (IDLE/BUSY/DONE)
//   reg_match() : register-index compare where r0 never matches
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W_BITS = 2;

  typedef logic [REG_W-1:0]      reg_idx_t;
  typedef logic [FWD_W_BITS-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  typedef logic [1:0] md_state_t;
  localparam md_state_t MD_IDLE = 2'd0;
  localparam md_state_t MD_BUSY = 2'd1;
  localparam md_state_t MD_DONE = 2'd2;

  // r0 is hardwired zero, so it never creates a dependency
  function automatic logic reg_match(input reg_idx_t a, input reg_idx_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy sequencer: IDLE -> BUSY (MD_LATENCY-1 cycles) -> DONE (1 cycle).
//   clk, rst     : clock, async active-high reset
//   md_start_i   : mult/div issued from E this cycle
//   md_busy_o    : high while in BUSY
//   md_done_o    : one-cycle pulse, HI/LO valid
module md_busy_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  output logic md_busy_o,
  output logic md_done_o
);

  localparam int unsigned TMR_W = $clog2(MD_LATENCY);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(MD_LATENCY - 1);

  md_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  // State and timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state; a start seen while BUSY is a protocol error and is ignored
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start_i) begin
          state_d = MD_BUSY;
          timer_d = TMR_RELOAD;
        end
      end
      MD_BUSY: begin
        if (timer_q == TMR_W'(1)) begin
          state_d = MD_DONE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      MD_DONE: begin
        if (md_start_i) begin
          state_d = MD_BUSY;
          timer_d = TMR_RELOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign md_busy_o = (state_q == MD_BUSY);
  assign md_done_o = (state_q == MD_DONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage pipeline.
//   Inputs : source regs in D/E, destination regs + write enables in E/M/W,
//            load flags in E/M, branch/redirect in D, mult/div issue and HI/LO use.
//   Outputs: stall_f/stall_d/flush_e (same-cycle hazard), flush_d (redirect),
//            E and D forwarding selects, md_busy/md_done, saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       write_reg_e,
  input  logic [4:0]       write_reg_m,
  input  logic [4:0]       write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             pcsrc_d,
  input  logic             md_start_e,
  input  logic             md_op_d,
  input  logic             hilo_read_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             lw_stall, br_stall, md_stall, hazard;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // E-stage operand select: M result is newer than W, so it wins
  function automatic fwd_sel_t fwd_e(input reg_idx_t src,
                                     input logic rw_m, input reg_idx_t wr_m,
                                     input logic rw_w, input reg_idx_t wr_w);
    if (rw_m && reg_match(wr_m, src))      return FWD_M;
    else if (rw_w && reg_match(wr_w, src)) return FWD_W;
    else                                   return FWD_RF;
  endfunction

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk        (clk),
    .rst        (rst),
    .md_start_i (md_start_e),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done)
  );

  // Hazard detection; branches compare in D so they need E results and M loads
  always_comb begin
    lw_stall = mem_to_reg_e && (reg_match(rt_e, rs_d) || reg_match(rt_e, rt_d));
    br_stall = branch_d &&
               ((reg_write_e  && (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d))) ||
                (mem_to_reg_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));
    md_stall = (md_busy || md_start_e) && (hilo_read_d || md_op_d);
    hazard   = (lw_stall || br_stall || md_stall) && !rst;
  end

  // Control outputs, all forced low while reset is asserted
  always_comb begin
    stall_f     = hazard;
    stall_d     = hazard;
    flush_e     = hazard;
    // A stalled redirect is dropped here and re-presented next cycle
    flush_d     = pcsrc_d && !hazard && !rst;
    forward_a_e = rst ? FWD_RF : fwd_e(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    forward_b_e = rst ? FWD_RF : fwd_e(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    forward_a_d = !rst && reg_write_m && reg_match(write_reg_m, rs_d);
    forward_b_d = !rst && reg_write_m && reg_match(write_reg_m, rt_d);
  end

  // Saturating count of stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;

endmodule
